sram_access_ctrl: RTL and testbench

- Datapath and handshake stage for the on-chip SRAM slave on abus. It sits directly downstream of the SRAM access FSM.
- Owns three jobs:
  - decodes the abus address window and produces addr_in_range;
  - runs the wait-state down-counter, loading it on counter_init and reporting counter_le1;
  - drives the single-port synchronous SRAM macro, captures read data in S_SAMPLE and returns a one-cycle abus_ack.
- Consumes current_state and counter_init from the FSM and feeds addr_in_range and counter_le1 back to it.

---
 rtl/sram_access_ctrl_pkg.sv | 36 +++
 rtl/sram_wait_counter.sv | 36 +++
 rtl/sram_access_ctrl.sv | 120 ++++++++++++
 tb/tb_sram_access_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_access_ctrl_pkg.sv
// ============================================================================
// Module   : sram_access_ctrl_pkg
// Brief    : Shared FSM state encoding, macro word width and parity helper for
//            the abus SRAM slave. Optional feature macro: SRAM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_access_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2
    } sram_state_e;

`ifdef SRAM_PARITY_EN
    localparam int MEM_W = 36;
`else
    localparam int MEM_W = 32;
`endif

    localparam int WAIT_CNT_W = 4;

    // One even-parity bit per byte: set when the byte has an odd number of ones.
    function automatic logic [3:0] byte_parity(input logic [31:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_wait_counter.sv
// ============================================================================
// Module   : sram_wait_counter
// Brief    : 4-bit loadable down-counter, saturating at zero, with <=1 flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_wait_counter
    import sram_access_ctrl_pkg::*;
#(
    parameter logic [WAIT_CNT_W-1:0] WAIT_STATE = 4'd2
) (
    input  logic abus_clk,
    input  logic abus_rstb,
    input  logic load,
    input  logic dec,
    output logic counter_le1
);

    logic [WAIT_CNT_W-1:0] r_count;

    always_ff @(posedge abus_clk or negedge abus_rstb) begin
        if (!abus_rstb) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= WAIT_STATE;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign counter_le1 = (r_count <= WAIT_CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/sram_access_ctrl.sv
// ============================================================================
// Module   : sram_access_ctrl
// Brief    : abus SRAM slave datapath: window decode, wait counter, macro
//            drive, read sample and ack. Optional macro: SRAM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_access_ctrl
    import sram_access_ctrl_pkg::*;
#(
    parameter int                WAIT_STATE = 2,
    parameter int                DEPTH      = 1024,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h2000_0000
) (
    input  logic                     abus_clk,
    input  logic                     abus_rstb,
    input  logic                     abus_sreq,
    input  logic                     abus_wr,
    input  logic [ADDR_W-1:0]        abus_addr,
    input  logic [31:0]              abus_wdata,
    input  logic [3:0]               abus_be,
    input  logic [1:0]               current_state,
    input  logic                     counter_init,
    output logic                     addr_in_range,
    output logic                     counter_le1,
    output logic                     sram_cs,
    output logic                     sram_we,
    output logic [$clog2(DEPTH)-1:0] sram_addr,
    output logic [MEM_W-1:0]         sram_wdata,
    output logic [MEM_W/8-1:0]       sram_wmask,
    input  logic [MEM_W-1:0]         sram_rdata,
    output logic                     abus_ack,
    output logic [31:0]              abus_rdata,
    output logic                     abus_err
);

    localparam int              AW_W      = $clog2(DEPTH);
    localparam logic [ADDR_W:0] C_WIN_END = {1'b0, BASE_ADDR} + (ADDR_W+1)'(4 * DEPTH);

    logic [ADDR_W-1:0] w_addr_off;
    logic              w_idle;
    logic              w_sample;
    logic              w_in_wait;
    logic              w_unused_addr;

    logic              r_wr_q;
    logic              r_ack;
    logic [31:0]       r_rdata;

    // Encoding 2'd3 is unreachable in a healthy FSM and is treated as idle.
    assign w_idle    = (current_state == S_IDLE) || (current_state == 2'd3);
    assign w_in_wait = (current_state == S_WAIT);
    assign w_sample  = (current_state == S_SAMPLE);

    assign addr_in_range = (abus_addr >= BASE_ADDR) && ({1'b0, abus_addr} < C_WIN_END);
    assign w_addr_off    = abus_addr - BASE_ADDR;
    assign w_unused_addr = ^{w_addr_off[ADDR_W-1:AW_W+2], w_addr_off[1:0]};

    assign sram_cs    = abus_sreq && addr_in_range && w_idle;
    assign sram_we    = abus_wr && sram_cs;
    assign sram_wmask = sram_we ? abus_be : '0;
    assign sram_addr  = w_addr_off[AW_W+1:2];

`ifdef SRAM_PARITY_EN
    assign sram_wdata = {byte_parity(abus_wdata), abus_wdata};
`else
    assign sram_wdata = abus_wdata;
`endif

    sram_wait_counter #(
        .WAIT_STATE (WAIT_CNT_W'(WAIT_STATE))
    ) u_wait_counter (
        .abus_clk    (abus_clk),
        .abus_rstb   (abus_rstb),
        .load        (counter_init),
        .dec         (w_in_wait),
        .counter_le1 (counter_le1)
    );

    always_ff @(posedge abus_clk or negedge abus_rstb) begin
        if (!abus_rstb) begin
            r_wr_q  <= 1'b0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (sram_cs) begin
                r_wr_q <= abus_wr;
            end
            r_ack <= w_sample;
            if (w_sample && !r_wr_q) begin
                r_rdata <= sram_rdata[31:0];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic r_err;

    always_ff @(posedge abus_clk or negedge abus_rstb) begin
        if (!abus_rstb) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_sample && !r_wr_q &&
                     (byte_parity(sram_rdata[31:0]) != sram_rdata[35:32]);
        end
    end

    assign abus_err = r_err;
`else
    assign abus_err = 1'b0;
`endif

    assign abus_ack   = r_ack;
    assign abus_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
// ============================================================================
// Module   : tb_sram_access_ctrl
// Brief    : Directed bench: instance A (WAIT_STATE=2), instance B (WAIT_STATE=0),
//            each with an FSM model and macro model. Honours SRAM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_access_ctrl;
    import sram_access_ctrl_pkg::*;

    localparam int WS_A  = 2;
    localparam int WS_B  = 0;
    localparam int DEPTH = 1024;

    logic        abus_clk = 1'b0;
    logic        abus_rstb = 1'b0;
    logic        sreq_a = 1'b0, sreq_b = 1'b0;
    logic        abus_wr = 1'b0;
    logic [31:0] abus_addr = '0;
    logic [31:0] abus_wdata = '0;
    logic [3:0]  abus_be = '0;
    logic        flip_a = 1'b0;

    logic             ld_a = 1'b0, ld_b = 1'b0;
    logic [9:0]       ld_addr = '0;
    logic [MEM_W-1:0] ld_data = '0;

    logic [1:0]         st_a, st_b;
    logic               in_a, in_b, le1_a, le1_b, cs_a, cs_b, we_a, we_b;
    logic [9:0]         sa_a, sa_b;
    logic [MEM_W-1:0]   wd_a, wd_b, rq_a, rq_b, rd_a;
    logic [MEM_W/8-1:0] wm_a, wm_b;
    logic               ack_a, ack_b, err_a, err_b;
    logic [31:0]        rdat_a, rdat_b;
    logic [MEM_W-1:0]   mem_a [DEPTH];
    logic [MEM_W-1:0]   mem_b [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

    always #5 abus_clk = ~abus_clk;

    assign rd_a = rq_a ^ {{(MEM_W-9){1'b0}}, flip_a, 8'h00};

    sram_access_ctrl #(.WAIT_STATE(WS_A), .DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h2000_0000)) dut_a (
        .abus_clk(abus_clk), .abus_rstb(abus_rstb), .abus_sreq(sreq_a), .abus_wr(abus_wr),
        .abus_addr(abus_addr), .abus_wdata(abus_wdata), .abus_be(abus_be),
        .current_state(st_a), .counter_init(st_a == S_IDLE), .addr_in_range(in_a),
        .counter_le1(le1_a), .sram_cs(cs_a), .sram_we(we_a), .sram_addr(sa_a),
        .sram_wdata(wd_a), .sram_wmask(wm_a), .sram_rdata(rd_a),
        .abus_ack(ack_a), .abus_rdata(rdat_a), .abus_err(err_a));

    sram_access_ctrl #(.WAIT_STATE(WS_B), .DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h2000_0000)) dut_b (
        .abus_clk(abus_clk), .abus_rstb(abus_rstb), .abus_sreq(sreq_b), .abus_wr(abus_wr),
        .abus_addr(abus_addr), .abus_wdata(abus_wdata), .abus_be(abus_be),
        .current_state(st_b), .counter_init(st_b == S_IDLE), .addr_in_range(in_b),
        .counter_le1(le1_b), .sram_cs(cs_b), .sram_we(we_b), .sram_addr(sa_b),
        .sram_wdata(wd_b), .sram_wmask(wm_b), .sram_rdata(rq_b),
        .abus_ack(ack_b), .abus_rdata(rdat_b), .abus_err(err_b));

    // Upstream access FSM model: launch, wait until counter <= 1, sample once.
    always_ff @(posedge abus_clk or negedge abus_rstb) begin
        if (!abus_rstb) begin
            st_a <= S_IDLE;
            st_b <= S_IDLE;
        end else begin
            case (st_a)
                S_IDLE:  if (sreq_a && in_a) st_a <= (WS_A == 0) ? S_SAMPLE : S_WAIT;
                S_WAIT:  if (le1_a) st_a <= S_SAMPLE;
                default: st_a <= S_IDLE;
            endcase
            case (st_b)
                S_IDLE:  if (sreq_b && in_b) st_b <= (WS_B == 0) ? S_SAMPLE : S_WAIT;
                S_WAIT:  if (le1_b) st_b <= S_SAMPLE;
                default: st_b <= S_IDLE;
            endcase
        end
    end

    // Single-port synchronous macro models with per-byte masks.
    always @(posedge abus_clk) begin
        if (ld_a) mem_a[ld_addr] <= ld_data;
        if (ld_b) mem_b[ld_addr] <= ld_data;
        if (cs_a) begin
            for (int i = 0; i < 4; i++) begin
                if (we_a && wm_a[i]) begin
                    mem_a[sa_a][8*i +: 8] <= wd_a[8*i +: 8];
`ifdef SRAM_PARITY_EN
                    mem_a[sa_a][32+i] <= wd_a[32+i];
`endif
                end
            end
            rq_a <= mem_a[sa_a];
        end
        if (cs_b) begin
            for (int i = 0; i < 4; i++) begin
                if (we_b && wm_b[i]) begin
                    mem_b[sa_b][8*i +: 8] <= wd_b[8*i +: 8];
`ifdef SRAM_PARITY_EN
                    mem_b[sa_b][32+i] <= wd_b[32+i];
`endif
                end
            end
            rq_b <= mem_b[sa_b];
        end
    end

    function automatic logic [MEM_W-1:0] mk(input logic [31:0] d);
`ifdef SRAM_PARITY_EN
        return {byte_parity(d), d};
`else
        return d;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic preload(input bit sel, input logic [9:0] a, input logic [31:0] d);
        @(posedge abus_clk); #1;
        ld_addr = a; ld_data = mk(d);
        if (sel) ld_b = 1'b1; else ld_a = 1'b1;
        @(posedge abus_clk); #1;
        ld_a = 1'b0; ld_b = 1'b0;
    endtask

    // Drives a request for one cycle; returns at the negedge of that cycle (cycle 0).
    task automatic req_start(input bit sel, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be);
        @(posedge abus_clk); #1;
        abus_wr = wr; abus_addr = a; abus_wdata = d; abus_be = be;
        if (sel) sreq_b = 1'b1; else sreq_a = 1'b1;
        @(negedge abus_clk);
    endtask

    // Counts cycles from the request to abus_ack; 0 means none within max.
    task automatic req_wait(input bit sel, input int max, output int l);
        l = 0;
        for (int k = 1; k <= max; k++) begin
            @(posedge abus_clk); #1;
            if (k == 1) begin sreq_a = 1'b0; sreq_b = 1'b0; end
            @(negedge abus_clk);
            if (sel ? ack_b : ack_a) begin l = k; break; end
        end
    endtask

    initial begin
        abus_rstb = 1'b0;
        preload(0, 10'd4, 32'hDEAD_BEEF);
        preload(0, 10'd0, 32'h0BAD_F00D);
        preload(0, 10'd1, 32'h1357_9BDF);
        preload(1, 10'd0, 32'hAABB_CCDD);
        preload(1, 10'd8, 32'h55AA_55AA);
        @(negedge abus_clk);
        check("rst_ack",   {62'd0, ack_a, ack_b}, 64'd0);
        check("rst_err",   {62'd0, err_a, err_b}, 64'd0);
        check("rst_rdata", {rdat_a, rdat_b}, 64'd0);
        check("rst_cnt",   64'(dut_a.u_wait_counter.r_count), 64'd0);
        abus_rstb = 1'b1;

        // Window edges (combinational decode).
        @(posedge abus_clk); #1; abus_addr = 32'h1FFF_FFFC;
        @(negedge abus_clk); check("dec_below", 64'(in_a), 64'd0);
        @(posedge abus_clk); #1; abus_addr = 32'h2000_0FFF;
        @(negedge abus_clk); check("dec_top", 64'(in_a), 64'd1);
        check("dec_top_addr", 64'(sa_a), 64'd1023);

        // Basic read, WAIT_STATE=2.
        req_start(0, 1'b0, 32'h2000_0010, 32'h0, 4'h0);
        check("rd_cs", 64'(cs_a), 64'd1);
        check("rd_addr", 64'(sa_a), 64'd4);
        check("rd_we", 64'(we_a), 64'd0);
        req_wait(0, 10, lat);
        check("rd_lat", 64'(lat), 64'd4);
        check("rd_data", 64'(rdat_a), 64'hDEAD_BEEF);
        check("rd_err", 64'(err_a), 64'd0);
        @(posedge abus_clk); #1;
        @(negedge abus_clk); check("ack_pulse", 64'(ack_a), 64'd0);

        // WAIT_STATE=0: read, write low bytes, read back.
        req_start(1, 1'b0, 32'h2000_0020, 32'h0, 4'h0);
        req_wait(1, 10, lat);
        check("b_rd_lat", 64'(lat), 64'd2);
        check("b_rd_data", 64'(rdat_b), 64'h55AA_55AA);
        req_start(1, 1'b1, 32'h2000_0000, 32'h1234_5678, 4'b0011);
        check("wr_we", 64'(we_b), 64'd1);
        check("wr_mask", 64'(wm_b), 64'd3);
        check("wr_data", 64'(wd_b[31:0]), 64'h1234_5678);
`ifdef SRAM_PARITY_EN
        check("wr_par", 64'(wd_b[35:32]), 64'h4);
`endif
        req_wait(1, 10, lat);
        check("wr_lat", 64'(lat), 64'd2);
        check("wr_rdata_hold", 64'(rdat_b), 64'h55AA_55AA);
        check("wr_err", 64'(err_b), 64'd0);
        req_start(1, 1'b0, 32'h2000_0000, 32'h0, 4'h0);
        req_wait(1, 10, lat);
        check("rb_lat", 64'(lat), 64'd2);
        check("rb_data", 64'(rdat_b), 64'hAABB_5678);

        // Just past the window.
        req_start(0, 1'b0, 32'h2000_1000, 32'h0, 4'h0);
        check("oor_range", 64'(in_a), 64'd0);
        check("oor_cs", 64'(cs_a), 64'd0);
        req_wait(0, 10, lat);
        check("oor_noack", 64'(lat), 64'd0);

        // Back-to-back reads, second request in the ack cycle.
        req_start(0, 1'b0, 32'h2000_0000, 32'h0, 4'h0);
        for (int k = 1; k <= 3; k++) begin @(posedge abus_clk); #1; sreq_a = 1'b0; end
        @(posedge abus_clk); #1;
        abus_addr = 32'h2000_0004; sreq_a = 1'b1;
        @(negedge abus_clk);
        check("b2b_ack1", 64'(ack_a), 64'd1);
        check("b2b_data1", 64'(rdat_a), 64'h0BAD_F00D);
        check("b2b_cs2", 64'(cs_a), 64'd1);
        check("b2b_addr2", 64'(sa_a), 64'd1);
        req_wait(0, 10, lat);
        check("b2b_gap", 64'(lat), 64'(WS_A + 2));
        check("b2b_data2", 64'(rdat_a), 64'h1357_9BDF);

        // Request during S_WAIT is ignored, then reset lands mid-access.
        req_start(0, 1'b0, 32'h2000_0010, 32'h0, 4'h0);
        @(posedge abus_clk); #1;
        @(negedge abus_clk); check("busy_nocs", 64'(cs_a), 64'd0);
        @(posedge abus_clk); #1; sreq_a = 1'b0;
        #2 abus_rstb = 1'b0;
        #1;
        check("mid_rst_ack", 64'(ack_a), 64'd0);
        check("mid_rst_rdata", 64'(rdat_a), 64'd0);
        check("mid_rst_cnt", 64'(dut_a.u_wait_counter.r_count), 64'd0);
        repeat (2) @(negedge abus_clk);
        check("in_rst_ack", 64'(ack_a), 64'd0);
        abus_rstb = 1'b1;
        req_start(0, 1'b0, 32'h2000_0010, 32'h0, 4'h0);
        req_wait(0, 10, lat);
        check("post_rst_lat", 64'(lat), 64'd4);
        check("post_rst_data", 64'(rdat_a), 64'hDEAD_BEEF);

`ifdef SRAM_PARITY_EN
        flip_a = 1'b1;
        req_start(0, 1'b0, 32'h2000_0010, 32'h0, 4'h0);
        req_wait(0, 10, lat);
        check("par_lat", 64'(lat), 64'd4);
        check("par_err", 64'(err_a), 64'd1);
        flip_a = 1'b0;
        req_start(0, 1'b0, 32'h2000_0010, 32'h0, 4'h0);
        req_wait(0, 10, lat);
        check("par_clean", 64'(err_a), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
